// File: rtl/bpm_pkg.sv
// Shared definitions for the BPM control blocks: hold FSM states, load-mode
// selectors and the saturating step helper.
package bpm_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2,
        FAST   = 2'd3
    } hold_state_t;

    localparam int LOAD_CLAMP  = 0;
    localparam int LOAD_REJECT = 1;

    // One guard bit keeps the add from wrapping and the subtract from
    // underflowing; callers zero-extend values up to 32 bits.
    function automatic logic [31:0] sat_step(
        input logic [31:0] v,
        input logic [31:0] step,
        input logic        up,
        input logic [31:0] lo,
        input logic [31:0] hi
    );
        logic [32:0] res;
        if (up) begin
            res = {1'b0, v} + {1'b0, step};
            if (res > {1'b0, hi})
                res = {1'b0, hi};
        end else begin
            if ({1'b0, v} < ({1'b0, lo} + {1'b0, step}))
                res = {1'b0, lo};
            else
                res = {1'b0, v} - {1'b0, step};
        end
        return res[31:0];
    endfunction

endpackage

// File: rtl/hold_repeat_timer.sv
// Hold-to-repeat FSM: delay, coarse repeats, then fast repeats. Emits a strike
// pulse per repeat; the parent decides whether the step is applied.
module hold_repeat_timer
    import bpm_pkg::*;
#(
    parameter int HOLD_DELAY    = 50000000,
    parameter int REPEAT_PERIOD = 10000000,
    parameter int ACCEL_COUNT   = 4
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic inc_hold,
    input  logic dec_hold,
    output logic strike,
    output logic dir_up,
    output logic fast
);

    localparam int MAX_T = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
    localparam int TW    = (MAX_T > 1) ? $clog2(MAX_T) : 1;
    localparam int RW    = (ACCEL_COUNT > 0) ? $clog2(ACCEL_COUNT + 1) : 1;
    localparam logic [TW-1:0] DELAY_END  = TW'(HOLD_DELAY - 1);
    localparam logic [TW-1:0] REPEAT_END = TW'(REPEAT_PERIOD - 1);

    hold_state_t   state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [RW-1:0] rep_q, rep_d;
    logic          dir_q, dir_d;
    logic          armed_q, armed_d;
    logic          held, both;

    assign held   = dir_q ? inc_hold : dec_hold;
    assign both   = inc_hold & dec_hold;
    assign dir_up = dir_q;
    assign fast   = (state_q == FAST);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        timer_d = (timer_q == '1) ? timer_q : timer_q + TW'(1);
        rep_d   = rep_q;
        dir_d   = dir_q;
        strike  = 1'b0;
        // A hold that survives reset must be released before it can re-arm.
        armed_d = armed_q | ~(inc_hold | dec_hold);

        if (state_q == IDLE) begin
            timer_d = '0;
            rep_d   = '0;
            if (armed_q && (inc_hold ^ dec_hold)) begin
                state_d = DELAY;
                dir_d   = inc_hold;
            end
        end else if (!held || both) begin
            state_d = IDLE;
            timer_d = '0;
            rep_d   = '0;
        end else begin
            case (state_q)
                DELAY: if (timer_q == DELAY_END) begin
                    strike  = 1'b1;
                    timer_d = '0;
                    rep_d   = RW'(1);
                    state_d = (ACCEL_COUNT <= 1) ? FAST : REPEAT;
                end
                REPEAT: if (timer_q == REPEAT_END) begin
                    strike  = 1'b1;
                    timer_d = '0;
                    rep_d   = rep_q + RW'(1);
                    if (int'(rep_q) + 1 >= ACCEL_COUNT)
                        state_d = FAST;
                end
                FAST: if (timer_q == REPEAT_END) begin
                    strike  = 1'b1;
                    timer_d = '0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (i_reset) begin
            state_q <= IDLE;
            timer_q <= '0;
            rep_q   <= '0;
            dir_q   <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            rep_q   <= rep_d;
            dir_q   <= dir_d;
            armed_q <= armed_d;
        end
    end

endmodule

// File: rtl/bpm_value_ctrl.sv
// BPM value register: arbitrates loads, button pulses and hold repeats, and
// saturates the result into [MIN_VAL, MAX_VAL].
module bpm_value_ctrl
    import bpm_pkg::*;
#(
    parameter int WIDTH         = 16,
    parameter int MIN_VAL       = 20,
    parameter int MAX_VAL       = 300,
    parameter int RESET_VAL     = 120,
    parameter int STEP_FINE     = 1,
    parameter int STEP_COARSE   = 5,
    parameter int STEP_FAST     = 10,
    parameter int HOLD_DELAY    = 50000000,
    parameter int REPEAT_PERIOD = 10000000,
    parameter int ACCEL_COUNT   = 4,
    parameter int LOAD_MODE     = LOAD_CLAMP
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_inc,
    input  logic             i_dec,
    input  logic             i_coarse,
    input  logic             i_inc_hold,
    input  logic             i_dec_hold,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    output logic [WIDTH-1:0] o_value,
    output logic             o_changed,
    output logic             o_at_min,
    output logic             o_at_max,
    output logic             o_load_err
);

    localparam logic [WIDTH-1:0] MIN_W   = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] value_q, value_d;
    logic             changed_q, load_err_q, load_err_d;
    logic             strike, dir_up, fast;

    hold_repeat_timer #(
        .HOLD_DELAY    (HOLD_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD),
        .ACCEL_COUNT   (ACCEL_COUNT)
    ) u_hold (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .inc_hold (i_inc_hold),
        .dec_hold (i_dec_hold),
        .strike   (strike),
        .dir_up   (dir_up),
        .fast     (fast)
    );

    always_comb begin
        value_d    = value_q;
        load_err_d = 1'b0;
        if (i_load) begin
            if (i_load_value > MAX_W) begin
                load_err_d = 1'b1;
                value_d    = (LOAD_MODE == LOAD_CLAMP) ? MAX_W : value_q;
            end else if (i_load_value < MIN_W) begin
                load_err_d = 1'b1;
                value_d    = (LOAD_MODE == LOAD_CLAMP) ? MIN_W : value_q;
            end else begin
                value_d = i_load_value;
            end
        end else if (i_inc || i_dec) begin
            // Simultaneous inc/dec cancels, and still masks any hold strike.
            if (i_inc ^ i_dec)
                value_d = WIDTH'(sat_step(32'(value_q),
                                          i_coarse ? 32'(STEP_COARSE) : 32'(STEP_FINE),
                                          i_inc, 32'(MIN_W), 32'(MAX_W)));
        end else if (strike) begin
            value_d = WIDTH'(sat_step(32'(value_q),
                                      fast ? 32'(STEP_FAST) : 32'(STEP_COARSE),
                                      dir_up, 32'(MIN_W), 32'(MAX_W)));
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            value_q    <= RESET_W;
            changed_q  <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            value_q    <= value_d;
            changed_q  <= (value_d != value_q);
            load_err_q <= load_err_d;
        end
    end

    assign o_value    = value_q;
    assign o_changed  = changed_q;
    assign o_load_err = load_err_q;
    assign o_at_min   = (value_q == MIN_W);
    assign o_at_max   = (value_q == MAX_W);

endmodule

// File: doc/bpm_value_ctrl.md
Name: bpm_value_ctrl

Overview:
Parametrised successor of the tempo value counter. Holds the current BPM value within a programmable [MIN_VAL, MAX_VAL] range. Accepts fine/coarse button steps, hold-to-repeat with acceleration, and UART absolute loads with range checking. Sits between the button debouncers/UART decoder and the beat-period generator; o_changed triggers period recomputation.

Parameters:
WIDTH, 16, bit width of value and load bus
MIN_VAL, 20, lower saturation bound
MAX_VAL, 300, upper saturation bound
RESET_VAL, 120, value after reset; must lie within [MIN_VAL, MAX_VAL]
STEP_FINE, 1, step for pulse with i_coarse=0
STEP_COARSE, 5, step for pulse with i_coarse=1, and first hold-repeat step
STEP_FAST, 10, hold-repeat step after acceleration
HOLD_DELAY, 50000000, cycles a hold level must persist before the first repeat
REPEAT_PERIOD, 10000000, cycles between repeats
ACCEL_COUNT, 4, repeats at STEP_COARSE before switching to STEP_FAST
LOAD_MODE, 0, 0 = clamp out-of-range loads; 1 = reject them

Ports:
i_clk  in  1  clock
i_reset  in  1  reset
i_inc  in  1  single-cycle increment pulse
i_dec  in  1  single-cycle decrement pulse
i_coarse  in  1  step select for i_inc/i_dec, sampled with the pulse
i_inc_hold  in  1  level, increment button held
i_dec_hold  in  1  level, decrement button held
i_load  in  1  single-cycle absolute load strobe
i_load_value  in  WIDTH  value to load
o_value  out  WIDTH  current BPM value, registered
o_changed  out  1  one-cycle pulse when o_value changed on this clock edge
o_at_min  out  1  o_value == MIN_VAL
o_at_max  out  1  o_value == MAX_VAL
o_load_err  out  1  one-cycle pulse: load rejected (LOAD_MODE=1) or clamped (LOAD_MODE=0)

Behaviour:
- Clock and reset: one clock, i_clk; synchronous active-high reset, i_reset.
- Reset state: o_value=RESET_VAL; o_changed=0; o_load_err=0; FSM=IDLE; timers and repeat count =0. Flags follow o_value combinationally from the register.
- Latency: every update is visible on o_value one cycle after the input cycle. o_changed and o_load_err pulse in that same cycle.
- Priority, highest first: i_load, then pulses (i_inc/i_dec), then hold repeat. A lower-priority event in the same cycle is dropped, not queued.
- i_inc and i_dec together: no change. i_inc_hold and i_dec_hold together: FSM forced to IDLE.
- Arithmetic: compute in WIDTH+1 bits with saturation. Increment gives min(v+step, MAX_VAL). Decrement gives max(v-step, MIN_VAL), with no underflow wrap.
- o_changed=1 only if the new value differs from the old one. A step at the bound gives o_changed=0.
- Load, i_load_value < MIN_VAL or > MAX_VAL:
  - LOAD_MODE=0: value clamps to the bound and o_load_err pulses.
  - LOAD_MODE=1: value is unchanged and o_load_err pulses.
- Load, in-range value: taken as-is, no error.
- Hold FSM, one instance; direction is latched on entry:
  - IDLE: exactly one hold level high -> DELAY, timer=0, dir latched.
  - DELAY: timer counts; at HOLD_DELAY-1 apply STEP_COARSE -> REPEAT, timer=0, rep=1.
  - REPEAT: at REPEAT_PERIOD-1 apply STEP_COARSE and rep++. When rep reaches ACCEL_COUNT -> FAST.
  - FAST: at REPEAT_PERIOD-1 apply STEP_FAST.
  - Any state: the latched hold level drops, or both hold levels are high -> IDLE, with no step that cycle.
  - A load or pulse in the cycle a repeat fires suppresses that step. The timer still restarts.
  - Reset mid-hold returns the FSM to IDLE. The hold must be released and re-asserted to repeat again.
- Timer width is clog2(max(HOLD_DELAY, REPEAT_PERIOD)). The timer saturates and never wraps.

Decomposition:
- Package bpm_pkg holds:
  - FSM state enum: IDLE, DELAY, REPEAT, FAST.
  - LOAD_CLAMP/LOAD_REJECT constants.
  - A saturating add/sub function shared with other BPM blocks.
- One sub-module, hold_repeat_timer: the FSM plus timer and repeat count. It outputs a step strike pulse and a fast flag. The top level does arbitration and saturation.

Test Plan:
Use HOLD_DELAY=8, REPEAT_PERIOD=4, ACCEL_COUNT=2; other parameters at default.
- Reset -> o_value=120, o_changed=0, o_at_min=o_at_max=0. Then i_inc, i_coarse=0 -> 121 next cycle with o_changed=1. Then i_dec, i_coarse=1 -> 116.
- Load 298, then i_inc coarse -> 300 with o_at_max=1. A second i_inc -> 300 with o_changed=0. Load 25, then three coarse i_dec -> 20, 20, 20 with o_at_min=1.
- LOAD_MODE=0, load 500 -> 300 with o_load_err=1. LOAD_MODE=1 from value 120, load 5 -> 120 with o_load_err=1 and o_changed=0. Load 200 -> 200 with o_load_err=0.
- i_inc_hold high from value 100 -> 105 eight cycles after entry, then 110, then 120, 130 every 4 cycles. Release -> no further change.
- Same cycle i_load=150 and i_inc=1 -> 150. Same cycle i_inc and i_dec -> unchanged. Both hold levels high -> no repeats.
- Assert i_reset during FAST -> 120 next cycle. Hold still high after reset -> no repeat until released and re-pressed.
